// File: rtl/umi_regfile_pkg.sv
// Shared register map for the UMI register bank: word indices and bit positions,
// imported by the RTL and by firmware-facing tests.
package umi_regfile_pkg;

  localparam int UMI_REGF_ID     = 0;
  localparam int UMI_REGF_CTRL   = 1;
  localparam int UMI_REGF_STATUS = 2;
  localparam int UMI_REGF_IRQEN  = 3;
  localparam int UMI_REGF_COUNT  = 4;
  localparam int UMI_REGF_ERR    = 5;
  localparam int UMI_REGF_SCR0   = 6;

  localparam int UMI_REGF_CTRL_EN = 0;  // COUNT runs while set
  localparam int UMI_REGF_ERR_OOR = 0;  // sticky: out-of-range address
  localparam int UMI_REGF_ERR_RW  = 1;  // sticky: read and write together

endpackage

// File: rtl/umi_regfile_if.sv
// Register-access bus between the UMI request decoder and the register bank.
// reg_read/reg_write are single-cycle strobes with no backpressure: the slave
// always accepts, and reg_rddata is valid the cycle after reg_read and held.
interface umi_regfile_if #(
  parameter int AW = 64,
  parameter int DW = 64
) ();
  logic [AW-1:0]   reg_addr;
  logic            reg_write;
  logic            reg_read;
  logic [3:0]      reg_size;
  logic [4*DW-1:0] reg_wrdata;
  logic [DW-1:0]   reg_rddata;

  modport master (
    output reg_addr, reg_write, reg_read, reg_size, reg_wrdata,
    input  reg_rddata
  );

  modport slave (
    input  reg_addr, reg_write, reg_read, reg_size, reg_wrdata,
    output reg_rddata
  );
endinterface

// File: rtl/umi_regfile_wmask.sv
// Byte-lane mask and lane-aligned write data from access size and byte offset.
// Lanes that would fall past the end of the word are dropped.
module umi_regfile_wmask #(
  parameter int DW = 64
) (
  input  logic [3:0]                 size,
  input  logic [$clog2(DW/8)-1:0]    off,
  input  logic [DW-1:0]              wrdata,
  output logic [DW/8-1:0]            lane_mask,
  output logic [DW-1:0]              lane_data
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);

  logic [NB-1:0] base;

  always_comb begin
    int lim;
    lim = (int'(size) >= OW) ? NB : (1 << size);
    base = '0;
    for (int i = 0; i < NB; i++) begin
      base[i] = (i < lim);
    end
    lane_mask = base << off;
    lane_data = wrdata << {off, 3'b000};
  end
endmodule

// File: rtl/umi_regfile.sv
// Control/status register bank behind the UMI register interface: ID, CTRL,
// W1C STATUS with interrupt, IRQEN, loadable cycle counter, ERR and scratch.
module umi_regfile
  import umi_regfile_pkg::*;
#(
  parameter int              AW    = 64,
  parameter int              DW    = 64,
  parameter int              NREGS = 16,
  parameter int              NEVT  = 8,
  parameter logic [DW-1:0]   REGID = '0
) (
  input  logic             clk,
  input  logic             reset,
  umi_regfile_if.slave     bus,
  input  logic [NEVT-1:0]  hw_event,
  output logic [DW-1:0]    ctrl,
  output logic             irq
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int NW = $clog2(NREGS);

  logic [NW-1:0]   idx;
  logic [OW-1:0]   off;
  logic            oor;
  logic            wr_en;
  logic [NB-1:0]   lane_mask;
  logic [DW-1:0]   lane_data;
  logic [DW-1:0]   bit_mask;
  logic [DW-1:0]   rd_word;
  logic [NEVT-1:0] st_clr;

  logic [DW-1:0]   ctrl_q, irqen, count;
  logic [NEVT-1:0] status;
  logic [1:0]      err;
  logic [DW-1:0]   scr [UMI_REGF_SCR0:NREGS-1];

  assign idx = bus.reg_addr[OW +: NW];
  assign off = bus.reg_addr[OW-1:0];
  // Any address bit between the index field and bit 15 marks the access out of range.
  assign oor   = |(bus.reg_addr[15:0] >> (OW + NW));
  assign wr_en = bus.reg_write && !bus.reg_read && !oor;
  assign ctrl  = ctrl_q;

  umi_regfile_wmask #(.DW(DW)) u_wmask (
    .size      (bus.reg_size),
    .off       (off),
    .wrdata    (bus.reg_wrdata[DW-1:0]),
    .lane_mask (lane_mask),
    .lane_data (lane_data)
  );

  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < NB; b++) begin
      bit_mask[8*b +: 8] = {8{lane_mask[b]}};
    end
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old);
    return (old & ~bit_mask) | (lane_data & bit_mask);
  endfunction

  assign st_clr = (wr_en && int'(idx) == UMI_REGF_STATUS) ? bit_mask[NEVT-1:0] : '0;

  always_comb begin
    rd_word = '0;
    if (!oor) begin
      case (int'(idx))
        UMI_REGF_ID:     rd_word = REGID;
        UMI_REGF_CTRL:   rd_word = ctrl_q;
        UMI_REGF_STATUS: rd_word = DW'(status);
        UMI_REGF_IRQEN:  rd_word = irqen;
        UMI_REGF_COUNT:  rd_word = count;
        UMI_REGF_ERR:    rd_word = DW'(err);
        default:         rd_word = scr[idx];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.reg_rddata <= '0;
      ctrl_q         <= '0;
      irqen          <= '0;
      count          <= '0;
      status         <= '0;
      err            <= '0;
      irq            <= 1'b0;
      for (int i = UMI_REGF_SCR0; i < NREGS; i++) begin
        scr[i] <= '0;
      end
    end else begin
      if (bus.reg_read) bus.reg_rddata <= rd_word;
      if ((bus.reg_read || bus.reg_write) && oor) err[UMI_REGF_ERR_OOR] <= 1'b1;
      if (bus.reg_read && bus.reg_write)          err[UMI_REGF_ERR_RW]  <= 1'b1;
      // Set wins over a simultaneous W1C.
      status <= (status & ~st_clr) | hw_event;
      if (wr_en && int'(idx) == UMI_REGF_CTRL)  ctrl_q <= merge(ctrl_q);
      if (wr_en && int'(idx) == UMI_REGF_IRQEN) irqen  <= merge(irqen);
      if (wr_en && int'(idx) == UMI_REGF_COUNT)  count <= merge(count);
      else if (ctrl_q[UMI_REGF_CTRL_EN])         count <= count + 1'b1;
      for (int i = UMI_REGF_SCR0; i < NREGS; i++) begin
        if (wr_en && int'(idx) == i) scr[i] <= merge(scr[i]);
      end
      irq <= |(status & irqen[NEVT-1:0]);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.reg_wrdata[4*DW-1:DW], bus.reg_addr[AW-1:16], irqen[DW-1:NEVT]};

endmodule

// File: tb/tb_umi_regfile.sv
// Directed bench for umi_regfile: reset values, byte-lane writes, counter wrap,
// W1C status/irq, out-of-range and read+write error handling, async reset.
module tb_umi_regfile;
  localparam logic [63:0] REGID = 64'h0123_4567_89AB_CDEF;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hw_event;
  logic [63:0] ctrl;
  logic       irq;
  int         total = 0;
  int         bad   = 0;

  umi_regfile_if #(.AW(64), .DW(64)) bus ();

  umi_regfile #(.AW(64), .DW(64), .NREGS(16), .NEVT(8), .REGID(REGID)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .hw_event (hw_event),
    .ctrl     (ctrl),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [3:0] sz);
    bus.reg_addr   = a;
    bus.reg_wrdata = {192'b0, d};
    bus.reg_size   = sz;
    bus.reg_write  = 1'b1;
    @(negedge clk);
    bus.reg_write  = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] d);
    bus.reg_addr = a;
    bus.reg_read = 1'b1;
    @(negedge clk);
    bus.reg_read = 1'b0;
    d = bus.reg_rddata;
  endtask

  initial begin
    logic [63:0] v;
    reset          = 1'b1;
    hw_event       = '0;
    bus.reg_addr   = '0;
    bus.reg_write  = 1'b0;
    bus.reg_read   = 1'b0;
    bus.reg_size   = 4'd3;
    bus.reg_wrdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("reset_irq", {63'b0, irq}, 64'h0);
    chk("reset_ctrl", ctrl, 64'h0);
    chk("reset_rddata", bus.reg_rddata, 64'h0);
    rd(64'h00, v); chk("reset_id", v, REGID);
    for (int i = 1; i < 16; i++) begin
      rd(64'(i * 8), v);
      chk($sformatf("reset_r%0d", i), v, 64'h0);
    end

    wr(64'h00, 64'hFFFF, 3);
    rd(64'h00, v); chk("id_ro", v, REGID);

    wr(64'h30, 64'h1122334455667788, 3);
    wr(64'h32, 64'hAA, 0);
    rd(64'h30, v); chk("scr6_byte", v, 64'h1122334455AA7788);
    wr(64'h3E, 64'hBBCC, 1);
    rd(64'h38, v); chk("scr7_half_top", v, 64'hBBCC000000000000);
    wr(64'h3F, 64'h1122, 1);
    rd(64'h38, v); chk("scr7_lane_drop", v, 64'h22CC000000000000);
    wr(64'h44, 64'h1122334455667788, 3);
    rd(64'h40, v); chk("scr8_off4", v, 64'h5566778800000000);

    wr(64'h08, 64'h1, 3);
    chk("ctrl_out", ctrl, 64'h1);
    wr(64'h20, 64'hFFFFFFFFFFFFFFFE, 3);
    repeat (3) @(negedge clk);
    rd(64'h20, v); chk("count_wrap", v, 64'h1);
    wr(64'h20, 64'h1234, 3);
    rd(64'h20, v); chk("count_load", v, 64'h1234);

    wr(64'h18, 64'h4, 3);
    hw_event = 8'h04;
    @(negedge clk);
    hw_event = 8'h00;
    chk("irq_lag", {63'b0, irq}, 64'h0);
    rd(64'h10, v); chk("status_set", v, 64'h4);
    chk("irq_set", {63'b0, irq}, 64'h1);
    hw_event = 8'h04;
    wr(64'h10, 64'h4, 3);
    hw_event = 8'h00;
    rd(64'h10, v); chk("status_set_wins", v, 64'h4);
    wr(64'h10, 64'h4, 3);
    rd(64'h10, v); chk("status_w1c", v, 64'h0);
    chk("irq_clr", {63'b0, irq}, 64'h0);
    hw_event = 8'h40;
    @(negedge clk);
    hw_event = 8'h00;
    rd(64'h10, v); chk("status_masked", v, 64'h40);
    chk("irq_masked", {63'b0, irq}, 64'h0);

    wr(64'hB0, 64'hDEAD, 3);
    rd(64'h30, v); chk("oor_no_write", v, 64'h1122334455AA7788);
    rd(64'hB0, v); chk("oor_read", v, 64'h0);
    rd(64'h28, v); chk("err_oor", v, 64'h1);
    wr(64'h28, 64'hFF, 3);
    rd(64'h28, v); chk("err_ro", v, 64'h1);

    bus.reg_addr   = 64'h38;
    bus.reg_wrdata = {192'b0, 64'h5555};
    bus.reg_size   = 4'd3;
    bus.reg_read   = 1'b1;
    bus.reg_write  = 1'b1;
    @(negedge clk);
    bus.reg_read   = 1'b0;
    bus.reg_write  = 1'b0;
    chk("rw_read", bus.reg_rddata, 64'h22CC000000000000);
    rd(64'h38, v); chk("rw_no_write", v, 64'h22CC000000000000);
    rd(64'h28, v); chk("err_rw", v, 64'h3);

    hw_event = 8'h04;
    @(negedge clk);
    hw_event = 8'h00;
    @(negedge clk);
    chk("irq_pre_reset", {63'b0, irq}, 64'h1);
    rd(64'h00, v); chk("id_pre_reset", v, REGID);
    #2 reset = 1'b1;
    #1;
    chk("arst_rddata", bus.reg_rddata, 64'h0);
    chk("arst_irq", {63'b0, irq}, 64'h0);
    chk("arst_ctrl", ctrl, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(64'h20, v); chk("arst_count", v, 64'h0);
    rd(64'h30, v); chk("arst_scr6", v, 64'h0);
    rd(64'h28, v); chk("arst_err", v, 64'h0);
    rd(64'h10, v); chk("arst_status", v, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
